tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter.sv | 70 +++++++
 tb/tb_tx_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin byte-stream arbiter feeding a TX FIFO (clk_i, reset_ni, arb_en_i, ch_valid_i/ch_data_i/ch_last_i -> ch_ready_o, tx_fifo_full_i -> tx_fifo_wen_o/tx_fifo_wdata_o, grant_o, busy_o)
module tx_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int MAX_BURST = 16,
  parameter int HDR_EN    = 1
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                arb_en_i,
  input  logic [NUM_CH-1:0]   ch_valid_i,
  input  logic [NUM_CH*8-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]   ch_last_i,
  output logic [NUM_CH-1:0]   ch_ready_o,
  input  logic                tx_fifo_full_i,
  output logic                tx_fifo_wen_o,
  output logic [7:0]          tx_fifo_wdata_o,
  output logic [NUM_CH-1:0]   grant_o,
  output logic                busy_o
);
  localparam int IW = $clog2(NUM_CH);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  logic [1:0] state;
  logic [IW-1:0] gidx, last_grant, nxt, k;
  logic [CW-1:0] cnt;
  logic hdr, dat, xfer, done;
  always_comb begin
    nxt = '0;
    k = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      k = IW'((int'(last_grant) + i) % NUM_CH);
      if (ch_valid_i[k]) nxt = k;
    end
  end
  assign hdr = state == HDR;
  assign dat = state == DATA;
  assign xfer = dat && ch_valid_i[gidx] && !tx_fifo_full_i;
  assign done = xfer && (ch_last_i[gidx] || cnt == CW'(MAX_BURST - 1));
  assign tx_fifo_wen_o = hdr ? !tx_fifo_full_i : xfer;
  assign tx_fifo_wdata_o = hdr ? (8'hA0 | 8'(gidx)) : dat ? ch_data_i[{gidx, 3'b000} +: 8] : 8'h00;
  assign ch_ready_o = (dat && !tx_fifo_full_i) ? grant_o : '0;
  assign busy_o = state != IDLE;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
      gidx <= '0;
      last_grant <= IW'(NUM_CH - 1);
      grant_o <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (arb_en_i && |ch_valid_i) begin
        gidx <= nxt;
        grant_o <= NUM_CH'(1) << nxt;
        cnt <= '0;
        state <= (HDR_EN != 0) ? HDR : DATA;
      end
    end else if (hdr) begin
      if (!tx_fifo_full_i) state <= DATA;
    end else begin
      if (xfer) cnt <= cnt + 1'b1;
      if (done) begin
        state <= IDLE;
        last_grant <= gidx;
        grant_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed self-checking bench for tx_arbiter (default, MAX_BURST=4 and HDR_EN=0 instances)
module tb_tx_arbiter;
  localparam int N = 4;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic reset_ni = 1'b0;
  logic arb_en_i = 1'b0;
  logic tx_fifo_full_i = 1'b0;
  logic [N-1:0] ch_valid_i = '0;
  logic [N-1:0] ch_last_i = '0;
  logic [N*8-1:0] ch_data_i = '0;
  logic [N-1:0] rdy [3];
  logic [N-1:0] gr [3];
  logic wen [3];
  logic bz [3];
  logic [7:0] wd [3];
  logic [8:0] mem [N][16];
  int head [N];
  int tail [N];
  logic [7:0] wlog [64];
  logic [7:0] wdl [64];
  logic [N-1:0] gl [64];
  logic [N-1:0] rl [64];
  logic wl [64];
  logic [7:0] exp_b [16];
  int cyc_n, wn, sel, full_lo, full_hi, total, bad;
  tx_arbiter #(.NUM_CH(N), .MAX_BURST(16), .HDR_EN(1)) dut0 (
    .clk_i(clk_i), .reset_ni(reset_ni), .arb_en_i(arb_en_i), .ch_valid_i(ch_valid_i),
    .ch_data_i(ch_data_i), .ch_last_i(ch_last_i), .ch_ready_o(rdy[0]), .tx_fifo_full_i(tx_fifo_full_i),
    .tx_fifo_wen_o(wen[0]), .tx_fifo_wdata_o(wd[0]), .grant_o(gr[0]), .busy_o(bz[0]));
  tx_arbiter #(.NUM_CH(N), .MAX_BURST(4), .HDR_EN(1)) dut1 (
    .clk_i(clk_i), .reset_ni(reset_ni), .arb_en_i(arb_en_i), .ch_valid_i(ch_valid_i),
    .ch_data_i(ch_data_i), .ch_last_i(ch_last_i), .ch_ready_o(rdy[1]), .tx_fifo_full_i(tx_fifo_full_i),
    .tx_fifo_wen_o(wen[1]), .tx_fifo_wdata_o(wd[1]), .grant_o(gr[1]), .busy_o(bz[1]));
  tx_arbiter #(.NUM_CH(N), .MAX_BURST(16), .HDR_EN(0)) dut2 (
    .clk_i(clk_i), .reset_ni(reset_ni), .arb_en_i(arb_en_i), .ch_valid_i(ch_valid_i),
    .ch_data_i(ch_data_i), .ch_last_i(ch_last_i), .ch_ready_o(rdy[2]), .tx_fifo_full_i(tx_fifo_full_i),
    .tx_fifo_wen_o(wen[2]), .tx_fifo_wdata_o(wd[2]), .grant_o(gr[2]), .busy_o(bz[2]));
  task push(input int ch, input logic [7:0] d, input logic l);
    mem[ch][tail[ch]] = {l, d};
    tail[ch]++;
  endtask
  task apply();
    for (int c = 0; c < N; c++) begin
      ch_valid_i[c] = head[c] < tail[c];
      {ch_last_i[c], ch_data_i[c*8 +: 8]} = (head[c] < tail[c]) ? mem[c][head[c]] : 9'h000;
    end
    tx_fifo_full_i = (cyc_n >= full_lo) && (cyc_n <= full_hi);
  endtask
  task cyc();
    logic [N-1:0] r;
    @(negedge clk_i);
    if (cyc_n < 64) begin
      gl[cyc_n] = gr[sel];
      rl[cyc_n] = rdy[sel];
      wl[cyc_n] = wen[sel];
      wdl[cyc_n] = wd[sel];
    end
    if (wen[sel] && wn < 64) begin
      wlog[wn] = wd[sel];
      wn++;
    end
    r = rdy[sel];
    cyc_n++;
    @(posedge clk_i);
    #1;
    for (int c = 0; c < N; c++) if (r[c] && ch_valid_i[c]) head[c]++;
    apply();
  endtask
  task run(input int n);
    repeat (n) cyc();
  endtask
  task start(input int s);
    sel = s;
    reset_ni = 1'b0;
    arb_en_i = 1'b0;
    for (int c = 0; c < N; c++) begin
      head[c] = 0;
      tail[c] = 0;
    end
    cyc_n = 0;
    wn = 0;
    full_lo = -1;
    full_hi = -1;
    apply();
    repeat (2) @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
  endtask
  task test_reset();
    sel = 0;
    reset_ni = 1'b0;
    full_lo = -1;
    full_hi = -1;
    cyc_n = 0;
    for (int c = 0; c < N; c++) begin
      head[c] = 0;
      tail[c] = 0;
    end
    push(0, 8'h5A, 1'b1);
    arb_en_i = 1'b1;
    apply();
    repeat (3) @(posedge clk_i);
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (gr[d] !== '0 || bz[d] !== 1'b0 || rdy[d] !== '0 || wen[d] !== 1'b0 || wd[d] !== 8'h00) begin
        bad++;
        $display("FAIL reset_outputs dut%0d: grant=%b busy=%b ready=%b wen=%b wdata=%h, required all zero", d, gr[d], bz[d], rdy[d], wen[d], wd[d]);
      end
    end
    @(negedge clk_i);
    reset_ni = 1'b1;
    #1;
    total++;
    if (gr[0] !== 4'b0000) begin
      bad++;
      $display("FAIL release_no_early_grant: grant=%b required 0000", gr[0]);
    end
    @(posedge clk_i);
    #1;
    total++;
    if (gr[0] !== 4'b0001 || bz[0] !== 1'b1) begin
      bad++;
      $display("FAIL first_grant_ch0: grant=%b busy=%b required 0001 1", gr[0], bz[0]);
    end
  endtask
  task test_single();
    int ng;
    start(0);
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h33, 1'b1);
    arb_en_i = 1'b1;
    apply();
    run(8);
    exp_b[0] = 8'hA1; exp_b[1] = 8'h11; exp_b[2] = 8'h22; exp_b[3] = 8'h33;
    total++;
    if (wn !== 4) begin
      bad++;
      $display("FAIL single_count: writes=%0d required 4", wn);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wlog[i] !== exp_b[i]) begin
        bad++;
        $display("FAIL single_byte%0d: got %h required %h", i, wlog[i], exp_b[i]);
      end
    end
    ng = 0;
    for (int i = 0; i < 8; i++) if (gl[i] == 4'b0010) ng++;
    total++;
    if (ng !== 4 || gl[0] !== 4'b0000 || gl[5] !== 4'b0000) begin
      bad++;
      $display("FAIL single_grant: cycles with 0010=%0d gl0=%b gl5=%b required 4 0000 0000", ng, gl[0], gl[5]);
    end
  endtask
  task test_round_robin();
    start(0);
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < N; c++) begin
        push(c, 8'(p ? 8'h20 + c : 8'h10 + c), 1'b1);
        exp_b[2*(4*p+c)] = 8'(8'hA0 + c);
        exp_b[2*(4*p+c)+1] = 8'(p ? 8'h20 + c : 8'h10 + c);
      end
    arb_en_i = 1'b1;
    apply();
    run(30);
    total++;
    if (wn !== 16) begin
      bad++;
      $display("FAIL rr_count: writes=%0d required 16", wn);
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (wlog[i] !== exp_b[i]) begin
        bad++;
        $display("FAIL rr_byte%0d: got %h required %h", i, wlog[i], exp_b[i]);
      end
    end
  endtask
  task test_burst_trunc();
    int rises;
    start(1);
    for (int i = 0; i < 6; i++) push(0, 8'(8'h30 + i), i == 5);
    arb_en_i = 1'b1;
    apply();
    run(14);
    exp_b[0] = 8'hA0; exp_b[1] = 8'h30; exp_b[2] = 8'h31; exp_b[3] = 8'h32;
    exp_b[4] = 8'h33; exp_b[5] = 8'hA0; exp_b[6] = 8'h34; exp_b[7] = 8'h35;
    total++;
    if (wn !== 8) begin
      bad++;
      $display("FAIL trunc_count: writes=%0d required 8", wn);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (wlog[i] !== exp_b[i]) begin
        bad++;
        $display("FAIL trunc_byte%0d: got %h required %h", i, wlog[i], exp_b[i]);
      end
    end
    rises = 0;
    for (int i = 1; i < 14; i++) if (gl[i] != 0 && gl[i-1] == 0) rises++;
    total++;
    if (rises !== 2 || gl[6] !== 4'b0000) begin
      bad++;
      $display("FAIL trunc_idle_gap: grants=%0d gl6=%b required 2 0000", rises, gl[6]);
    end
  endtask
  task test_fifo_full();
    start(0);
    for (int i = 0; i < 6; i++) push(2, 8'(8'h40 + i), i == 5);
    full_lo = 3;
    full_hi = 7;
    arb_en_i = 1'b1;
    apply();
    run(16);
    for (int c = 3; c <= 7; c++) begin
      total++;
      if (wl[c] !== 1'b0 || rl[c] !== 4'b0000) begin
        bad++;
        $display("FAIL full_stall%0d: wen=%b ready=%b required 0 0000", c, wl[c], rl[c]);
      end
    end
    total++;
    if (wn !== 7) begin
      bad++;
      $display("FAIL full_count: writes=%0d required 7", wn);
    end
    exp_b[0] = 8'hA2;
    for (int i = 0; i < 6; i++) exp_b[i+1] = 8'(8'h40 + i);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (wlog[i] !== exp_b[i]) begin
        bad++;
        $display("FAIL full_byte%0d: got %h required %h", i, wlog[i], exp_b[i]);
      end
    end
  endtask
  task test_reset_mid();
    start(0);
    for (int i = 0; i < 6; i++) push(3, 8'(8'h50 + i), i == 5);
    arb_en_i = 1'b1;
    apply();
    run(4);
    total++;
    if (wn !== 3 || wlog[2] !== 8'h51) begin
      bad++;
      $display("FAIL rmid_pre: writes=%0d last=%h required 3 51", wn, wlog[2]);
    end
    reset_ni = 1'b0;
    #1;
    total++;
    if (gr[0] !== '0 || bz[0] !== 1'b0 || rdy[0] !== '0 || wen[0] !== 1'b0 || wd[0] !== 8'h00) begin
      bad++;
      $display("FAIL rmid_async: grant=%b busy=%b ready=%b wen=%b wdata=%h required all zero", gr[0], bz[0], rdy[0], wen[0], wd[0]);
    end
    push(0, 8'h60, 1'b1);
    apply();
    @(posedge clk_i);
    #1;
    total++;
    if (wen[0] !== 1'b0 || gr[0] !== '0) begin
      bad++;
      $display("FAIL rmid_held: wen=%b grant=%b required 0 0000", wen[0], gr[0]);
    end
    reset_ni = 1'b1;
    wn = 0;
    cyc_n = 0;
    run(12);
    exp_b[0] = 8'hA0; exp_b[1] = 8'h60; exp_b[2] = 8'hA3; exp_b[3] = 8'h52;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wlog[i] !== exp_b[i]) begin
        bad++;
        $display("FAIL rmid_byte%0d: got %h required %h", i, wlog[i], exp_b[i]);
      end
    end
  endtask
  task test_no_hdr();
    start(2);
    push(2, 8'h70, 1'b0);
    push(2, 8'h71, 1'b1);
    apply();
    run(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (gl[i] !== 4'b0000) begin
        bad++;
        $display("FAIL nohdr_disabled%0d: grant=%b required 0000", i, gl[i]);
      end
    end
    total++;
    if (wn !== 0) begin
      bad++;
      $display("FAIL nohdr_nowrite: writes=%0d required 0", wn);
    end
    arb_en_i = 1'b1;
    cyc_n = 0;
    apply();
    run(6);
    total++;
    if (gl[0] !== 4'b0000 || gl[1] !== 4'b0100 || wl[1] !== 1'b1 || wdl[1] !== 8'h70) begin
      bad++;
      $display("FAIL nohdr_data_next: gl0=%b gl1=%b wen=%b wdata=%h required 0000 0100 1 70", gl[0], gl[1], wl[1], wdl[1]);
    end
    total++;
    if (wn !== 2 || wlog[0] !== 8'h70 || wlog[1] !== 8'h71) begin
      bad++;
      $display("FAIL nohdr_stream: writes=%0d b0=%h b1=%h required 2 70 71", wn, wlog[0], wlog[1]);
    end
  endtask
  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_trunc();
    test_fifo_full();
    test_reset_mid();
    test_no_hdr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
